// File: rtl/run_scheduler.sv
// run_scheduler: round-robin time-slicing scheduler sharing one start/stop run engine.
// Define RUN_SCHED_WATCHDOG_EN to add a handshake timeout with a sticky err output.
module run_scheduler #(
  parameter int N_REQ   = 4,
  parameter int SLICE_W = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N_REQ-1:0]   req,
  input  logic [SLICE_W-1:0] slice_len,
  input  logic               eng_running,
  output logic               eng_start,
  output logic               eng_stop,
  output logic [N_REQ-1:0]   grant,
`ifdef RUN_SCHED_WATCHDOG_EN
  output logic               err,
`endif
  output logic               busy
);

  // state     | meaning
  // S_IDLE    | no owner, waiting for any request
  // S_ARB     | round-robin search from the pointer
  // S_LAUNCH  | start pulse to the engine
  // S_WAIT_UP | waiting for eng_running to rise
  // S_RUN     | engine running, slice counting
  // S_HALT    | stop pulse to the engine
  // S_WAIT_DN | waiting for eng_running to fall
  typedef enum logic [2:0] {
    S_IDLE,
    S_ARB,
    S_LAUNCH,
    S_WAIT_UP,
    S_RUN,
    S_HALT,
    S_WAIT_DN
  } state_t;

  localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  state_t             state_q, state_d;
  logic [N_REQ-1:0]   grant_q, grant_d;
  logic [PW-1:0]      ptr_q, ptr_d;
  logic [PW-1:0]      owner_q, owner_d;
  logic [SLICE_W-1:0] cnt_q, cnt_d;
  logic               start_q, start_d;
  logic               stop_q, stop_d;
  logic               busy_q, busy_d;
  logic               win_found;
  logic [PW-1:0]      win_idx;
  logic [PW-1:0]      ptr_next;
`ifdef RUN_SCHED_WATCHDOG_EN
  logic [3:0]         wd_q, wd_d;
  logic               err_q, err_d;
`endif

  function automatic logic [PW-1:0] wrap_add(input logic [PW-1:0] base, input int off);
    int s;
    s = int'(base) + off;
    if (s >= N_REQ) s = s - N_REQ;
    return PW'(s);
  endfunction

  // Descending scan so the smallest offset from the pointer is written last and wins.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (req[wrap_add(ptr_q, i)]) begin
        win_found = 1'b1;
        win_idx   = wrap_add(ptr_q, i);
      end
    end
  end

  assign ptr_next = wrap_add(owner_q, 1);

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    ptr_d   = ptr_q;
    owner_d = owner_q;
    cnt_d   = cnt_q;
    start_d = 1'b0;
    stop_d  = 1'b0;
`ifdef RUN_SCHED_WATCHDOG_EN
    wd_d    = wd_q;
    err_d   = err_q;
`endif
    case (state_q)
      S_IDLE: begin
        grant_d = '0;
        if (|req) state_d = S_ARB;
      end
      S_ARB: begin
        grant_d = '0;
        if (win_found) begin
          grant_d[win_idx] = 1'b1;
          owner_d          = win_idx;
          start_d          = 1'b1;
          state_d          = S_LAUNCH;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_LAUNCH: begin
        state_d = S_WAIT_UP;
`ifdef RUN_SCHED_WATCHDOG_EN
        wd_d    = '0;
`endif
      end
      S_WAIT_UP: begin
        if (eng_running) begin
          state_d = S_RUN;
          cnt_d   = slice_len;
        end
`ifdef RUN_SCHED_WATCHDOG_EN
        else if (wd_q == 4'd14) begin
          state_d = S_ARB;
          grant_d = '0;
          ptr_d   = ptr_next;
          err_d   = 1'b1;
        end else begin
          wd_d = wd_q + 4'd1;
        end
`endif
      end
      S_RUN: begin
        // A self-terminated engine needs no stop pulse, so that exit takes priority.
        if (!eng_running) begin
          state_d = S_ARB;
          grant_d = '0;
          ptr_d   = ptr_next;
        end else if ((cnt_q == SLICE_W'(1)) || !req[owner_q]) begin
          state_d = S_HALT;
          stop_d  = 1'b1;
        end else if (cnt_q != '0) begin
          cnt_d = cnt_q - SLICE_W'(1);
        end
      end
      S_HALT: begin
        state_d = S_WAIT_DN;
`ifdef RUN_SCHED_WATCHDOG_EN
        wd_d    = '0;
`endif
      end
      S_WAIT_DN: begin
        if (!eng_running) begin
          state_d = S_ARB;
          grant_d = '0;
          ptr_d   = ptr_next;
        end
`ifdef RUN_SCHED_WATCHDOG_EN
        else if (wd_q == 4'd14) begin
          state_d = S_ARB;
          grant_d = '0;
          ptr_d   = ptr_next;
          err_d   = 1'b1;
        end else begin
          wd_d = wd_q + 4'd1;
        end
`endif
      end
      default: begin
        state_d = S_IDLE;
        grant_d = '0;
      end
    endcase
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      grant_q <= '0;
      ptr_q   <= '0;
      owner_q <= '0;
      cnt_q   <= '0;
      start_q <= 1'b0;
      stop_q  <= 1'b0;
      busy_q  <= 1'b0;
`ifdef RUN_SCHED_WATCHDOG_EN
      wd_q    <= '0;
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      ptr_q   <= ptr_d;
      owner_q <= owner_d;
      cnt_q   <= cnt_d;
      start_q <= start_d;
      stop_q  <= stop_d;
      busy_q  <= busy_d;
`ifdef RUN_SCHED_WATCHDOG_EN
      wd_q    <= wd_d;
      err_q   <= err_d;
`endif
    end
  end

  assign eng_start = start_q;
  assign eng_stop  = stop_q;
  assign grant     = grant_q;
  assign busy      = busy_q;
`ifdef RUN_SCHED_WATCHDOG_EN
  assign err       = err_q;
`endif

endmodule
